// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// datapath mux selects, ALU class codes and the RV32I base opcodes.
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IF    = 3'd0,
        ST_ID    = 3'd1,
        ST_EX    = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_LINK  = 3'd5,
        ST_PCINC = 3'd6,
        ST_HALT  = 3'd7
    } state_t;

    // ALU class codes; 2'b11 is reserved and never driven.
    localparam logic [1:0] CLS_ADD    = 2'd0;
    localparam logic [1:0] CLS_BRANCH = 2'd1;
    localparam logic [1:0] CLS_FUNCT  = 2'd2;

    localparam logic       SRC_A_PC  = 1'b0;
    localparam logic       SRC_A_REG = 1'b1;

    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_ALU    = 2'd2;

    localparam logic       PCSRC_ALU    = 1'b0;
    localparam logic       PCSRC_ALUOUT = 1'b1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // True for the two opcodes that use the MEM step.
    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mc_control_unit_next_state.sv
// Combinational next-state function of the multi-cycle control FSM.
//
// state | meaning
// IF    | fetch; wait for memory, load IR
// ID    | decode; ALUOut <= PC + imm (branch/JAL target)
// EX    | execute by opcode
// MEM   | data memory access for LOAD/STORE
// WB    | register write-back plus PC+4
// LINK  | JALR: rd <= PC+4, PC <= ALUOut
// PCINC | branch not taken: PC <= PC+4
// HALT  | stopped by ECALL, exits only through reset
module mc_control_unit_next_state
    import mc_control_unit_pkg::*;
(
    input  state_t     i_state,
    input  logic [6:0] i_opcode,
    input  logic       i_mem_ready,
    input  logic       i_bcond,
    input  logic       i_ecall_halt,
    output state_t     o_next_state
);

    // Next-state selection; mem_ready only matters in IF and MEM.
    always_comb begin
        o_next_state = i_state;
        case (i_state)
            ST_IF:    o_next_state = i_mem_ready ? ST_ID : ST_IF;
            ST_ID:    o_next_state = ST_EX;
            ST_EX: begin
                case (i_opcode)
                    OPC_OP, OPC_OP_IMM:   o_next_state = ST_WB;
                    OPC_LOAD, OPC_STORE:  o_next_state = ST_MEM;
                    OPC_BRANCH:           o_next_state = i_bcond ? ST_IF : ST_PCINC;
                    OPC_JAL:              o_next_state = ST_IF;
                    OPC_JALR:             o_next_state = ST_LINK;
                    OPC_SYSTEM:           o_next_state = i_ecall_halt ? ST_HALT : ST_IF;
                    default:              o_next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                // A non-memory opcode here cannot occur; recover to fetch rather than hang.
                if (!is_mem_op(i_opcode)) begin
                    o_next_state = ST_IF;
                end else if (i_mem_ready) begin
                    o_next_state = (i_opcode == OPC_LOAD) ? ST_WB : ST_IF;
                end
            end
            ST_WB, ST_LINK, ST_PCINC: o_next_state = ST_IF;
            ST_HALT:  o_next_state = ST_HALT;
            default:  o_next_state = ST_IF;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: state register plus per-state datapath
// control decode. All outputs are combinational and forced low in reset.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int ALU_CLS_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [6:0]           i_opcode,
    input  logic                 i_bcond,
    input  logic                 i_mem_ready,
    input  logic                 i_ecall_halt,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_i_or_d,
    output logic                 o_ir_write,
    output logic                 o_mdr_write,
    output logic                 o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [ALU_CLS_W-1:0] o_alu_cls,
    output logic                 o_reg_write,
    output logic [1:0]           o_wb_sel,
    output logic                 o_pc_write,
    output logic                 o_pc_source,
    output logic                 o_is_ecall,
    output logic                 o_retire,
    output logic                 o_is_halted
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_alu_cls;

    mc_control_unit_next_state u_next_state (
        .i_state      (r_state),
        .i_opcode     (i_opcode),
        .i_mem_ready  (i_mem_ready),
        .i_bcond      (i_bcond),
        .i_ecall_halt (i_ecall_halt),
        .o_next_state (w_next_state)
    );

    // State register; reset always returns to fetch and clears HALT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign o_alu_cls = ALU_CLS_W'(w_alu_cls);

    // Per-state control decode; every PC+4 step routes PC and 4 through the live ALU.
    always_comb begin
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_i_or_d    = 1'b0;
        o_ir_write  = 1'b0;
        o_mdr_write = 1'b0;
        o_alu_src_a = SRC_A_PC;
        o_alu_src_b = SRC_B_REG;
        w_alu_cls   = CLS_ADD;
        o_reg_write = 1'b0;
        o_wb_sel    = WB_ALUOUT;
        o_pc_write  = 1'b0;
        o_pc_source = PCSRC_ALU;
        o_is_ecall  = 1'b0;
        o_retire    = 1'b0;
        o_is_halted = 1'b0;
        if (!i_reset) begin
            case (r_state)
                ST_IF: begin
                    o_mem_read = 1'b1;
                    o_ir_write = i_mem_ready;
                end
                ST_ID: begin
                    o_alu_src_b = SRC_B_IMM;
                end
                ST_EX: begin
                    case (i_opcode)
                        OPC_OP: begin
                            o_alu_src_a = SRC_A_REG;
                            w_alu_cls   = CLS_FUNCT;
                        end
                        OPC_OP_IMM: begin
                            o_alu_src_a = SRC_A_REG;
                            o_alu_src_b = SRC_B_IMM;
                            w_alu_cls   = CLS_FUNCT;
                        end
                        OPC_LOAD, OPC_STORE, OPC_JALR: begin
                            o_alu_src_a = SRC_A_REG;
                            o_alu_src_b = SRC_B_IMM;
                        end
                        OPC_BRANCH: begin
                            o_alu_src_a = SRC_A_REG;
                            w_alu_cls   = CLS_BRANCH;
                            if (i_bcond) begin
                                o_pc_write  = 1'b1;
                                o_pc_source = PCSRC_ALUOUT;
                                o_retire    = 1'b1;
                            end
                        end
                        OPC_JAL: begin
                            o_alu_src_b = SRC_B_FOUR;
                            o_reg_write = 1'b1;
                            o_wb_sel    = WB_ALU;
                            o_pc_write  = 1'b1;
                            o_pc_source = PCSRC_ALUOUT;
                            o_retire    = 1'b1;
                        end
                        OPC_SYSTEM: begin
                            o_is_ecall = 1'b1;
                            if (!i_ecall_halt) begin
                                o_alu_src_b = SRC_B_FOUR;
                                o_pc_write  = 1'b1;
                                o_retire    = 1'b1;
                            end
                        end
                        default: begin
                            o_alu_src_b = SRC_B_FOUR;
                            o_pc_write  = 1'b1;
                            o_retire    = 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    o_i_or_d = 1'b1;
                    if (i_opcode == OPC_LOAD) begin
                        o_mem_read  = 1'b1;
                        o_mdr_write = i_mem_ready;
                    end else if (i_opcode == OPC_STORE) begin
                        o_mem_write = 1'b1;
                        if (i_mem_ready) begin
                            o_alu_src_b = SRC_B_FOUR;
                            o_pc_write  = 1'b1;
                            o_retire    = 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    o_reg_write = 1'b1;
                    o_wb_sel    = (i_opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                    o_alu_src_b = SRC_B_FOUR;
                    o_pc_write  = 1'b1;
                    o_retire    = 1'b1;
                end
                ST_LINK: begin
                    o_alu_src_b = SRC_B_FOUR;
                    o_reg_write = 1'b1;
                    o_wb_sel    = WB_ALU;
                    o_pc_write  = 1'b1;
                    o_pc_source = PCSRC_ALUOUT;
                    o_retire    = 1'b1;
                end
                ST_PCINC: begin
                    o_alu_src_b = SRC_B_FOUR;
                    o_pc_write  = 1'b1;
                    o_retire    = 1'b1;
                end
                ST_HALT: begin
                    o_is_halted = 1'b1;
                end
                default: begin
                    o_is_halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle full output vectors for each
// instruction class, stall and reset cases, plus a latency table.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       mem_ready;
    logic       ecall_halt;
    logic       mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a;
    logic [1:0] alu_src_b, alu_cls, wb_sel;
    logic       reg_write, pc_write, pc_source, is_ecall, retire, is_halted;

    int vectors = 0;
    int miscompares = 0;
    int mdr_count;
    int ncyc;
    int lat;

    logic [17:0] obs;
    assign obs = {mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_src_a,
                  alu_src_b, alu_cls, reg_write, wb_sel, pc_write, pc_source,
                  is_ecall, retire, is_halted};

    mc_control_unit #(.ALU_CLS_W(2)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_opcode     (opcode),
        .i_bcond      (bcond),
        .i_mem_ready  (mem_ready),
        .i_ecall_halt (ecall_halt),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_i_or_d     (i_or_d),
        .o_ir_write   (ir_write),
        .o_mdr_write  (mdr_write),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_alu_cls    (alu_cls),
        .o_reg_write  (reg_write),
        .o_wb_sel     (wb_sel),
        .o_pc_write   (pc_write),
        .o_pc_source  (pc_source),
        .o_is_ecall   (is_ecall),
        .o_retire     (retire),
        .o_is_halted  (is_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector, arguments in the same order as obs.
    function automatic logic [17:0] ov(input int mr, input int mw, input int iod, input int irw,
                                        input int mdrw, input int sa, input int sb, input int cls,
                                        input int rw, input int wbs, input int pw, input int ps,
                                        input int ec, input int ret, input int h);
        return {mr[0], mw[0], iod[0], irw[0], mdrw[0], sa[0], sb[1:0], cls[1:0],
                rw[0], wbs[1:0], pw[0], ps[0], ec[0], ret[0], h[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic rdy, input logic bc, input logic eh);
        opcode     = opc;
        mem_ready  = rdy;
        bcond      = bc;
        ecall_halt = eh;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [17:0] o, input logic [17:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_st(input string tag, input state_t o, input state_t e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%s expected=%s", tag, o.name(), e.name());
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Runs one instruction from IF with memory always ready; returns cycles up to and including retire (0 on timeout).
    task automatic run_lat(input logic [6:0] opc, input logic bc, input logic eh, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(opc, 1'b1, bc, eh);
            if (retire === 1'b1) begin
                cyc = k;
                break;
            end
            tick();
        end
        tick();
    endtask

    logic [6:0] lat_opc [10];
    logic       lat_bc  [10];
    int         lat_exp [10];

    initial begin
        lat_opc = '{OPC_JAL, OPC_BRANCH, OPC_SYSTEM, 7'b0000000, OPC_OP_IMM,
                    OPC_OP, OPC_STORE, OPC_JALR, OPC_BRANCH, OPC_LOAD};
        lat_bc  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        lat_exp = '{3, 3, 3, 3, 4, 4, 4, 4, 4, 5};

        reset = 1'b1; opcode = 7'd0; bcond = 1'b0; mem_ready = 1'b0; ecall_halt = 1'b0;
        #2;
        chk_out("reset_outs", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        tick();
        drive(OPC_OP, 1'b1, 1'b0, 1'b0);
        chk_out("reset_outs_ready_hi", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;
        #1;

        // ADD
        chk_out("add_if", obs, ov(1,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        chk_st("add_if_state", dut.r_state, ST_IF);
        tick(); drive(OPC_OP, 1'b1, 1'b0, 1'b0);
        chk_out("add_id", obs, ov(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_OP, 1'b1, 1'b0, 1'b0);
        chk_out("add_ex", obs, ov(0,0,0,0,0,1,0,2,0,0,0,0,0,0,0));
        tick(); drive(OPC_OP, 1'b1, 1'b0, 1'b0);
        chk_out("add_wb", obs, ov(0,0,0,0,0,0,2,0,1,0,1,0,0,1,0));
        chk_st("add_wb_state", dut.r_state, ST_WB);
        tick();

        // LOAD with two stall cycles in IF and in MEM
        mdr_count = 0;
        ncyc = 0;
        for (int k = 0; k < 2; k++) begin
            drive(OPC_LOAD, 1'b0, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
            chk_out("ld_if_stall", obs, ov(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
            tick();
        end
        drive(OPC_LOAD, 1'b1, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
        chk_out("ld_if", obs, ov(1,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_LOAD, 1'b0, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
        chk_out("ld_id_ready_ignored", obs, ov(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_LOAD, 1'b1, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
        chk_out("ld_ex", obs, ov(0,0,0,0,0,1,1,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 2; k++) begin
            tick(); drive(OPC_LOAD, 1'b0, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
            chk_out("ld_mem_stall", obs, ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
        end
        tick(); drive(OPC_LOAD, 1'b1, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
        chk_out("ld_mem", obs, ov(1,0,1,0,1,0,0,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_LOAD, 1'b0, 1'b0, 1'b0); ncyc++; mdr_count += int'(mdr_write);
        chk_out("ld_wb", obs, ov(0,0,0,0,0,0,2,0,1,1,1,0,0,1,0));
        chk_int("ld_cycles", ncyc, 9);
        chk_int("ld_mdr_writes", mdr_count, 1);
        tick();

        // BEQ taken
        drive(OPC_BRANCH, 1'b1, 1'b1, 1'b0);
        tick(); drive(OPC_BRANCH, 1'b1, 1'b1, 1'b0);
        tick(); drive(OPC_BRANCH, 1'b1, 1'b1, 1'b0);
        chk_out("beq_t_ex", obs, ov(0,0,0,0,0,1,0,1,0,0,1,1,0,1,0));
        tick();
        chk_st("beq_t_next_if", dut.r_state, ST_IF);

        // BEQ not taken
        drive(OPC_BRANCH, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_BRANCH, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_BRANCH, 1'b1, 1'b0, 1'b0);
        chk_out("beq_nt_ex", obs, ov(0,0,0,0,0,1,0,1,0,0,0,0,0,0,0));
        tick(); drive(OPC_BRANCH, 1'b1, 1'b1, 1'b0);
        chk_st("beq_nt_pcinc_state", dut.r_state, ST_PCINC);
        chk_out("beq_nt_pcinc", obs, ov(0,0,0,0,0,0,2,0,0,0,1,0,0,1,0));
        tick();

        // JALR
        drive(OPC_JALR, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_JALR, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_JALR, 1'b1, 1'b0, 1'b0);
        chk_out("jalr_ex", obs, ov(0,0,0,0,0,1,1,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_JALR, 1'b1, 1'b0, 1'b0);
        chk_st("jalr_link_state", dut.r_state, ST_LINK);
        chk_out("jalr_link", obs, ov(0,0,0,0,0,0,2,0,1,2,1,1,0,1,0));
        tick();

        // JAL
        drive(OPC_JAL, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_JAL, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_JAL, 1'b1, 1'b0, 1'b0);
        chk_out("jal_ex", obs, ov(0,0,0,0,0,0,2,0,1,2,1,1,0,1,0));
        tick();

        // ECALL without halt
        drive(OPC_SYSTEM, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_SYSTEM, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_SYSTEM, 1'b1, 1'b0, 1'b0);
        chk_out("ecall_run_ex", obs, ov(0,0,0,0,0,0,2,0,0,0,1,0,1,1,0));
        tick();
        chk_st("ecall_run_next_if", dut.r_state, ST_IF);

        // Latency table
        for (int i = 0; i < 10; i++) begin
            run_lat(lat_opc[i], lat_bc[i], 1'b0, lat);
            chk_int($sformatf("latency_%0d_opc%b", i, lat_opc[i]), lat, lat_exp[i]);
        end

        // Reset asserted while a store stalls in MEM
        drive(OPC_STORE, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_STORE, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_STORE, 1'b1, 1'b0, 1'b0);
        tick(); drive(OPC_STORE, 1'b0, 1'b0, 1'b0);
        chk_out("st_mem_stall", obs, ov(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b1;
        #1;
        chk_out("st_mem_reset_outs", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_st("st_mem_reset_state", dut.r_state, ST_IF);
        tick(); drive(OPC_STORE, 1'b1, 1'b0, 1'b0);
        chk_out("reset_hold_outs", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b0;
        #1;
        chk_out("post_reset_if", obs, ov(1,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
        chk_st("post_reset_state", dut.r_state, ST_IF);

        // ECALL with halt
        tick(); drive(OPC_SYSTEM, 1'b1, 1'b0, 1'b1);
        tick(); drive(OPC_SYSTEM, 1'b1, 1'b0, 1'b1);
        chk_out("ecall_halt_ex", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
        for (int k = 0; k < 4; k++) begin
            tick(); drive(OPC_SYSTEM, k[0], 1'b1, 1'b0);
            chk_out("halted_outs", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
            chk_st("halted_state", dut.r_state, ST_HALT);
        end
        reset = 1'b1;
        #1;
        chk_out("halt_reset_outs", obs, ov(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        tick(); drive(OPC_OP, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk_out("halt_release_if", obs, ov(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_st("halt_release_state", dut.r_state, ST_IF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control FSM for the RV32I CPU. It sequences the shared datapath (one ALU, one unified memory, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It emits a 2-bit ALU class code that the existing ALU control decoder expands using funct3/funct7. It handles variable-latency memory through a ready handshake and stops the CPU on ECALL when the halt condition is true.

Parameters:
ALU_CLS_W, 2, width of alu_cls output (00 ADD, 01 BRANCH-compare, 10 FUNCT-decoded, 11 reserved).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high.
opcode  input  7  IR[6:0]; valid from ID onward.
bcond  input  1  ALU branch-condition result; sampled in EX of BRANCH.
mem_ready  input  1  memory completes the current read/write this cycle.
ecall_halt  input  1  datapath flag, x17==10; sampled in EX of ECALL.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
i_or_d  output  1  memory address: 0 PC, 1 ALUOut.
ir_write  output  1  load IR from memory data.
mdr_write  output  1  load MDR from memory data.
alu_src_a  output  1  0 PC, 1 A.
alu_src_b  output  2  0 B, 1 IMM, 2 constant 4.
alu_cls  output  ALU_CLS_W  ALU operation class.
reg_write  output  1  register file write enable.
wb_sel  output  2  rd data: 0 ALUOut, 1 MDR, 2 live ALU result.
pc_write  output  1  PC update enable.
pc_source  output  1  0 live ALU result, 1 ALUOut.
is_ecall  output  1  high in EX of ECALL.
retire  output  1  one-cycle pulse in the cycle the instruction's final PC write occurs.
is_halted  output  1  sticky halt flag.

Behaviour:
- States: IF, ID, EX, MEM, WB, LINK, PCINC, HALT; 3-bit encoding. Reset sets the state to IF.
- Outputs are combinational from state, opcode, mem_ready and bcond. Any output not listed for a state is 0. While reset is high, every output is 0.
- IF: mem_read=1, i_or_d=0. If mem_ready=1, ir_write=1 and go to ID; otherwise stay in IF.
- ID: alu_src_a=PC, alu_src_b=IMM, alu_cls=ADD; ALUOut gets the branch/JAL target. Go to EX.
- EX, by opcode:
  - ARITHMETIC / ARITHMETIC_IMM: src_a=A, src_b=B or IMM, alu_cls=FUNCT; go to WB.
  - LOAD / STORE: A+IMM with ADD; go to MEM.
  - BRANCH: src_a=A, src_b=B, alu_cls=BRANCH. If bcond=1: pc_write=1, pc_source=1, retire=1, go to IF. If bcond=0: go to PCINC.
  - JAL: src_a=PC, src_b=4, ADD, reg_write=1, wb_sel=2, pc_write=1, pc_source=1, retire=1; go to IF.
  - JALR: A+IMM into ALUOut; go to LINK.
  - ECALL: is_ecall=1. If ecall_halt=1, go to HALT with no PC write. Otherwise PC+4 with pc_source=0, pc_write=1, retire=1; go to IF.
  - Any other opcode: executes as a NOP, PC+4 with retire=1; go to IF.
- MEM: i_or_d=1. LOAD drives mem_read=1; STORE drives mem_write=1.
  - Request signals stay stable until mem_ready=1.
  - LOAD on ready: mdr_write=1, go to WB.
  - STORE on ready: PC+4 (src_a=PC, src_b=4, ADD), pc_write=1, pc_source=0, retire=1; go to IF.
- WB: reg_write=1, wb_sel=1 for LOAD and 0 otherwise. In the same cycle PC+4 is written with pc_source=0, retire=1; go to IF.
- LINK: PC+4 goes to rd (wb_sel=2, reg_write=1); pc_write=1, pc_source=1, retire=1; go to IF.
- PCINC: PC+4 with pc_write=1, pc_source=0, retire=1; go to IF.
- HALT: terminal. is_halted=1 and all other outputs 0 until reset.
- Latency in cycles, with memory ready immediately:
  - 3: JAL, ECALL no-halt, branch taken.
  - 4: ALU ops, store, JALR, branch not taken.
  - 5: load.
  - Each memory stall cycle adds one cycle.
- Reset asserted in any state, including mid-stall: outputs drop to 0 immediately. After release the FSM starts in IF and is_halted is cleared.
- mem_ready is ignored outside IF and MEM.

Decomposition:
- New shared header mc_control_defs.v holds the state encodings and the alu_cls, alu_src_b, wb_sel and pc_source encodings.
- Opcode constants come from opcodes.v.
- One optional sub-module, mc_next_state_logic, holds the combinational next-state function. Output decode stays in mc_control_unit.

Test Plan:
- reset pulse mid-MEM, then release, mem_ready=1 -> outputs 0 during reset; next cycle mem_read=1, i_or_d=0, state IF.
- ADD (opcode 0110011), mem_ready=1 -> IF, ID, EX (alu_cls=10, alu_src_a=1, alu_src_b=0), WB (reg_write=1, wb_sel=0, pc_write=1); retire pulses at cycle 4.
- LOAD with mem_ready held low 2 cycles in both IF and MEM -> 9 cycles total; mem_read stable throughout; mdr_write exactly once; WB has wb_sel=1.
- BEQ with bcond=1 -> retire at cycle 3 with pc_source=1. BEQ with bcond=0 -> PCINC state, retire at cycle 4 with pc_source=0.
- JALR -> EX then LINK with reg_write=1, wb_sel=2, pc_source=1. JAL -> all of these in EX at cycle 3.
- ECALL with ecall_halt=0 -> retire at cycle 3. ECALL with ecall_halt=1 -> is_halted=1 permanently, pc_write stays 0, and mem_ready toggling has no effect until reset.
